// File: rtl/led_pkg.sv
// Shared LED subsystem defaults, consumed by the trail PWM and the upstream rotator.
package led_pkg;

  localparam int unsigned LED_N_LED_DEF     = 8;
  localparam int unsigned LED_BRIGHT_W_DEF  = 4;
  localparam int unsigned LED_DECAY_DIV_DEF = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned led_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: decaying brightness level, per-frame shadow duty and PWM compare.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned BRIGHT_W = LED_BRIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_led,
  input  logic                i_decay_tick,
  input  logic                i_load_duty,
  input  logic [BRIGHT_W-1:0] i_pwm_cnt,
  output logic                o_pwm
);

  localparam logic [BRIGHT_W-1:0] LMAX = '1;

  logic [BRIGHT_W-1:0] r_level;
  logic [BRIGHT_W-1:0] r_duty;
  logic                r_pwm;

  // Brightness: a lit input always wins over a decay step; decay saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (!i_en) begin
      r_level <= '0;
    end else if (i_led) begin
      r_level <= LMAX;
    end else if (i_decay_tick && (r_level != '0)) begin
      r_level <= r_level - BRIGHT_W'(1);
    end
  end

  // Duty is only refreshed on the last count of a frame so a frame never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
    end else if (!i_en) begin
      r_duty <= '0;
    end else if (i_load_duty) begin
      r_duty <= r_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else if (!i_en) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_duty > i_pwm_cnt);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver: shared PWM/decay counters plus one PWM channel per LED.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int unsigned BRIGHT_W  = LED_BRIGHT_W_DEF,
  parameter int unsigned DECAY_DIV = LED_DECAY_DIV_DEF,
  parameter int unsigned N_LED     = LED_N_LED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] pwm_out,
  output logic             frame_tick
);

  localparam int unsigned         DEC_W    = led_cnt_w(DECAY_DIV);
  localparam logic [DEC_W-1:0]    DEC_LAST = DEC_W'(DECAY_DIV - 1);
  localparam logic [BRIGHT_W-1:0] LMAX     = '1;

  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic [DEC_W-1:0]    r_decay_cnt;
  logic                r_frame_tick;
  logic                w_decay_tick;
  logic                w_frame_end;
  logic [N_LED-1:0]    w_pwm;

  assign w_decay_tick = en && (r_decay_cnt == DEC_LAST);
  assign w_frame_end  = en && (r_pwm_cnt == LMAX);

  // Shared counters; dropping en parks everything at 0 so restart is deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt    <= '0;
      r_decay_cnt  <= '0;
      r_frame_tick <= 1'b0;
    end else if (!en) begin
      r_pwm_cnt    <= '0;
      r_decay_cnt  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_pwm_cnt    <= r_pwm_cnt + BRIGHT_W'(1);
      r_decay_cnt  <= (r_decay_cnt == DEC_LAST) ? '0 : r_decay_cnt + DEC_W'(1);
      r_frame_tick <= w_frame_end;
    end
  end

  for (genvar g = 0; g < int'(N_LED); g++) begin : g_ch
    led_pwm_channel #(
      .BRIGHT_W (BRIGHT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (en),
      .i_led        (led_in[g]),
      .i_decay_tick (w_decay_tick),
      .i_load_duty  (w_frame_end),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_pwm        (w_pwm[g])
    );
  end

  assign pwm_out    = w_pwm;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm: cycle reference model feeding an expected-output queue.
module tb_led_trail_pwm;

  localparam int NL   = 8;
  localparam int DD   = 4;
  localparam int LMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NL-1:0] led_in;
  logic [NL-1:0] pwm_out;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  logic [NL:0] exp_q[$];
  logic [NL:0] obs;
  logic [NL:0] expv;

  // Reference model state
  int            m_pwm;
  int            m_dec;
  int            m_lvl[NL];
  int            m_duty[NL];
  logic [NL-1:0] m_out;
  logic          m_ft;

  always #5 clk = ~clk;

  led_trail_pwm #(
    .BRIGHT_W  (4),
    .DECAY_DIV (DD),
    .N_LED     (NL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .led_in     (led_in),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  task automatic model_reset();
    m_pwm = 0;
    m_dec = 0;
    m_out = '0;
    m_ft  = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_lvl[i]  = 0;
      m_duty[i] = 0;
    end
  endtask

  // Advance the model one edge for the given inputs.
  task automatic model_step(input logic e, input logic [NL-1:0] l);
    bit dtick;
    bit load;
    if (!e) begin
      model_reset();
    end else begin
      dtick = (m_dec == DD - 1);
      load  = (m_pwm == LMAX);
      for (int i = 0; i < NL; i++) begin
        m_out[i] = (m_duty[i] > m_pwm);
        if (load) m_duty[i] = m_lvl[i];
        if (l[i]) m_lvl[i] = LMAX;
        else if (dtick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
      end
      m_ft  = load;
      m_pwm = (m_pwm + 1) % (LMAX + 1);
      m_dec = (m_dec + 1) % DD;
    end
  endtask

  // Drive one cycle, queue the expected output, sample the DUT after the edge.
  task automatic drive_cycle(input logic e, input logic [NL-1:0] l);
    en     = e;
    led_in = l;
    model_step(e, l);
    exp_q.push_back({m_ft, m_out});
    @(posedge clk);
    #1;
    obs = {frame_tick, pwm_out};
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    led_in = '0;
    model_reset();
    #12;
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL reset_pwm: got %h want 00", pwm_out);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_led();
    int seen;
    int cnt0;
    logic [NL-1:0] others;
    seen   = 0;
    cnt0   = 0;
    others = '0;
    for (int c = 0; c < 80 && seen < 2; c++) begin
      drive_cycle(1'b1, 8'h01);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL single_led c=%0d: got %h want %h", c, obs, expv);
      end
      if (obs[NL]) seen++;
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL single_led_frame_timeout: got %0d ticks want 2", seen);
    end
    for (int c = 0; c < 16; c++) begin
      if (c > 0) drive_cycle(1'b1, 8'h01);
      else begin
        expv = {1'b1, obs[NL-1:0]};
        exp_q.push_back(expv);
      end
      expv = exp_q.pop_front();
      if (c > 0) begin
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL single_led_win c=%0d: got %h want %h", c, obs, expv);
        end
      end
      cnt0   += int'(obs[0]);
      others |= obs[NL-1:0] & 8'hFE;
    end
    checks++;
    if (cnt0 != 15) begin
      errors++;
      $display("FAIL single_led_duty: got %0d high want 15 of 16", cnt0);
    end
    checks++;
    if (others !== '0) begin
      errors++;
      $display("FAIL single_led_others: got %h want 00", others);
    end
  endtask

  task automatic test_decay();
    int cnt0;
    cnt0 = 0;
    for (int c = 0; c < 120; c++) begin
      drive_cycle(1'b1, (c < 20) ? 8'h01 : 8'h00);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL decay c=%0d: got %h want %h", c, obs, expv);
      end
    end
    for (int c = 0; c < 32; c++) begin
      drive_cycle(1'b1, 8'h00);
      void'(exp_q.pop_front());
      cnt0 += int'(obs[0]);
    end
    checks++;
    if (cnt0 != 0) begin
      errors++;
      $display("FAIL decay_floor: got %0d high cycles want 0", cnt0);
    end
  endtask

  task automatic test_set_on_decay();
    int guard;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 8'h08);
      void'(exp_q.pop_front());
    end
    guard = 0;
    while (!(m_lvl[3] == 7 && m_dec == DD - 1) && guard < 200) begin
      drive_cycle(1'b1, 8'h00);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL set_on_decay_pre: got %h want %h", obs, expv);
      end
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL set_on_decay_timeout: got %0d cycles want <200", guard);
    end
    for (int c = 0; c < 70; c++) begin
      drive_cycle(1'b1, (c == 0) ? 8'h08 : 8'h00);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL set_on_decay c=%0d: got %h want %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_en_drop();
    int wait_cyc;
    for (int c = 0; c < 40 && !(c >= 20 && m_pwm == 7); c++) begin
      drive_cycle(1'b1, 8'hA5);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, 8'hA5);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv || obs !== '0) begin
        errors++;
        $display("FAIL en_drop c=%0d: got %h want %h", c, obs, expv);
      end
    end
    wait_cyc = 0;
    for (int c = 1; c <= 40 && wait_cyc == 0; c++) begin
      drive_cycle(1'b1, 8'h00);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL en_restart c=%0d: got %h want %h", c, obs, expv);
      end
      if (obs[NL]) wait_cyc = c;
    end
    checks++;
    if (wait_cyc != 16) begin
      errors++;
      $display("FAIL en_restart_tick: got %0d cycles want 16", wait_cyc);
    end
  endtask

  task automatic test_comet();
    logic [NL-1:0] pat;
    for (int r = 0; r < 2 * NL; r++) begin
      pat = 8'h01 << (r % NL);
      for (int c = 0; c < 16; c++) begin
        drive_cycle(1'b1, pat);
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL comet r=%0d c=%0d: got %h want %h", r, c, obs, expv);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          e;
    logic [NL-1:0] l;
    for (int c = 0; c < 200; c++) begin
      e = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      drive_cycle(e, l);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got %h want %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (m_out !== 8'hFF && guard < 60) begin
      drive_cycle(1'b1, 8'hFF);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL async_reset_pre: got %h want %h", obs, expv);
      end
      guard++;
    end
    checks++;
    if (pwm_out !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset_setup: got %h want ff", pwm_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL async_reset_pwm: got %h want 00", pwm_out);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_tick: got %b want 0", frame_tick);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, 8'h00);
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL after_reset c=%0d: got %h want %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_led();
    test_decay();
    test_set_on_decay();
    test_en_drop();
    test_comet();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 Parameter BRIGHT_W, default 4: brightness level width; levels 0..2^BRIGHT_W-1 (LMAX).
REQ-002 Parameter DECAY_DIV, default 16: clk cycles per decay step; legal range >=1.
REQ-003 Parameter N_LED, default 8: channel count.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  block enable; synchronous.
REQ-007 led_in  input  N_LED  one-hot-style LED pattern from the upstream rotator; any bit pattern legal.
REQ-008 pwm_out  output  N_LED  registered PWM drive per LED, 1 = lit.
REQ-009 frame_tick  output  1  registered one-cycle pulse marking a PWM frame boundary.

Function
REQ-010 pwm_cnt: free-running BRIGHT_W-bit up counter, 0..LMAX, wraps LMAX->0, advances every cycle while en=1.
REQ-011 decay_cnt: counts 0..DECAY_DIV-1, wraps to 0; decay_tick asserted in the cycle decay_cnt==DECAY_DIV-1 and en=1.
REQ-012 Per channel i, level[i] (BRIGHT_W bits) update priority: led_in[i]=1 -> LMAX; else decay_tick=1 and level[i]>0 -> level[i]-1; else hold.
REQ-013 led_in[i]=1 coincident with decay_tick: level[i] = LMAX (set wins, no decrement).
REQ-014 level[i] saturates at 0; never wraps to LMAX on decay.
REQ-015 duty[i]: shadow copy of level[i], loaded only in cycles where pwm_cnt==LMAX; duty is constant within a frame (glitch-free PWM).
REQ-016 pwm_out[i] registered: value in cycle t+1 = (duty[i] > pwm_cnt) evaluated in cycle t; duty LMAX gives LMAX of 2^BRIGHT_W cycles high, duty 0 gives constant 0.
REQ-017 frame_tick = 1 in the cycle after pwm_cnt==LMAX with en=1; otherwise 0.
REQ-018 Latency: led_in[i] rising to first pwm_out[i] high at most 2^BRIGHT_W+2 cycles (wait for frame boundary, shadow load, output register).
REQ-019 Decay from LMAX to 0 takes exactly LMAX*DECAY_DIV decay-count cycles after led_in[i] falls, given continuous en=1.
REQ-020 en=0: next cycle pwm_cnt, decay_cnt, level, duty cleared to 0; pwm_out and frame_tick 0; held so while en=0.
REQ-021 en 0->1: pwm_cnt and decay_cnt count from 0; first frame_tick 2^BRIGHT_W cycles after en rises.
REQ-022 DECAY_DIV=1: decay_tick every enabled cycle.

Reset
REQ-023 rst_n low: pwm_cnt, decay_cnt, all level and duty values, pwm_out, frame_tick forced to 0 immediately, independent of clk.
REQ-024 Reset asserted mid-frame or mid-decay discards all state; after release behaviour equals en 0->1 (REQ-021).
REQ-025 Reset deassertion is synchronised externally; no internal synchroniser.

Structure
REQ-026 Shared package led_pkg holds N_LED default (8), default BRIGHT_W, default DECAY_DIV; same package consumed by the upstream rotator.
REQ-027 Sub-module led_pwm_channel: one instance per LED (generate loop), contains level, duty and output compare for one channel; counters and decay_tick stay in the top.
REQ-028 No combinational path from led_in or en to any output.

Verification (BRIGHT_W=4, DECAY_DIV=4)
REQ-029 Reset: rst_n=0 mid-run with pwm_out=8'hFF -> pwm_out=8'h00, frame_tick=0 without clock edge.
REQ-030 led_in=8'h01 held -> after first frame_tick, pwm_out[0] high 15 of every 16 cycles, pwm_out[7:1]=0.
REQ-031 led_in bit0 1->0 -> level[0] 15,14,..0 one step per 4 cycles, 0 after 60 cycles; pwm_out[0] duty changes only at frame boundaries, then constant 0.
REQ-032 led_in[3] rises exactly on decay_tick while level[3]=7 -> level[3]=15, not 14.
REQ-033 en dropped mid-frame with levels nonzero -> next cycle pwm_out=0, levels 0; en re-raised -> frame_tick after 16 cycles.
REQ-034 Rotating input 8'h01->8'h02->... every 16 cycles -> comet trail: leading LED duty 15, previous LEDs decreasing by 4 per frame, checked against reference model.
